blood_sensor_rx: RTL and testbench
==================================

Name: blood_sensor_rx

Overview:
- Sensor-side front end that feeds the glycemic index calculator.
- Receives the blood sensor's serial UART-style frame, checks start, parity and stop, and assembles the 8-bit bloodSensor word.
- Presents bloodSensor with a one-cycle valid strobe. The existing combinational GlycemicIndexCalculator consumes bloodSensor directly.
- Frame: idle-high line, 1 start bit (0), 8 data bits MSB first, 1 even-parity bit, 1 stop bit (1).

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4.
- DATA_W, 8, data bits per frame; fixed at 8 for the calculator interface.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sensorRx  in  1  asynchronous serial line from the sensor; idles high.
- bloodSensor  out  8  last correctly received sample; feeds GlycemicIndexCalculator.bloodSensor.
- sensorValid  out  1  one-cycle pulse: bloodSensor has just been updated.
- parityError  out  1  one-cycle pulse: frame discarded for bad parity.
- frameError  out  1  one-cycle pulse: frame discarded because the stop bit sampled 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (sync, active-high), applied next edge:
  - bloodSensor = 8'h00; sensorValid, parityError, frameError, busy = 0.
  - FSM = IDLE; bit timer, bit counter and shift register = 0.
  - Synchronizer flops = 1.
- Reset mid-frame aborts the frame with no error pulse. The next frame is accepted only after a new 1->0 edge.
- Input sync: sensorRx passes through a 2-flop synchronizer (rxS). All decisions use rxS. Latency is 2 clk.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when rxS == 0, go to START and load timer = CLKS_PER_BIT/2 - 1.
  - START: at timer == 0 (mid start bit):
    - rxS == 0: go to DATA, timer = CLKS_PER_BIT - 1, bitCnt = 0.
    - rxS == 1: false start; return to IDLE, no error pulse.
  - DATA: at each timer expiry, shift rxS in MSB first (shift <= {shift[6:0], rxS}), bitCnt++, reload timer. After the 8th sample go to PARITY.
  - PARITY: at expiry, latch rxS as parity bit. Go to STOP.
  - STOP: at expiry (mid stop bit), then IDLE:
    - rxS == 1 and ^{shift, parityBit} == 0: bloodSensor <= shift, sensorValid pulses the next cycle.
    - rxS == 1 and parity odd: parityError pulses, bloodSensor unchanged.
    - rxS == 0: frameError pulses, bloodSensor unchanged, go to BREAK instead of IDLE. Frame error has priority over parity error.
  - BREAK: wait until rxS == 1, then IDLE. A stuck-low line produces exactly one frameError.
- Timing:
  - Samples fall at mid-bit: CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after start detection, k = 0..10.
  - With the default CLKS_PER_BIT = 16, sensorValid rises 2 + 8 + 160 + 1 = 171 clk after the sensorRx falling edge.
- Output timing:
  - All outputs are registered.
  - Pulses are exactly one cycle wide and mutually exclusive.
  - bloodSensor changes only in the same cycle sensorValid is high.
- Back-to-back frames: IDLE is reached at mid stop bit, so a start edge immediately after the stop bit is caught. No idle gap is required.
- busy: 1 from the cycle after START entry until the cycle IDLE is re-entered.

Decomposition:
- Shared package blood_sensor_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - SENSOR_DATA_W = 8.
  - even_parity(data, p) function.
- Sub-module sync_2ff: 2-flop synchronizer with reset value 1, reused for other async sensor inputs.
- Bit timer, bit counter and FSM stay in blood_sensor_rx.

Test Plan:
- Frame 8'b11101110, parity 0, stop 1 (CLKS_PER_BIT = 16) -> sensorValid high for one cycle exactly 171 clk after the falling edge; bloodSensor = 8'hEE; no error pulses.
- Back-to-back frames 8'h7C, 8'h9D, 8'hFF, 8'h00 with no idle gap -> four sensorValid pulses 176 clk apart; bloodSensor steps 7C, 9D, FF, 00.
- Frame 8'h55 sent with parity bit 1 -> parityError pulses once; sensorValid stays 0; bloodSensor keeps its previous value (e.g. 8'h00).
- Frame 8'hAA with stop bit 0, line held low 40 bit times -> one frameError pulse; FSM stays in BREAK; the next valid frame 8'h81 after the line returns high -> bloodSensor = 8'h81.
- Glitch: sensorRx low for 5 clk, then high -> FSM returns to IDLE from START; no pulses; busy drops within 8 clk.
- rst asserted for 1 clk midway through frame 8'hFE -> all outputs 0 the next cycle; the remaining bits of the aborted frame are ignored; the following full frame 8'h80 -> bloodSensor = 8'h80 with sensorValid.

Source files
------------

// File: rtl/blood_sensor_pkg.sv
// Shared types and helpers for the blood sensor receive path.
package blood_sensor_pkg;

    localparam int unsigned SENSOR_DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_t;

    // True when data plus its parity bit carry an even number of ones.
    function automatic logic even_parity(input logic [SENSOR_DATA_W-1:0] data, input logic p);
        return ~(^{data, p});
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous sensor lines; resets to the idle-high level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic syncOut
);

    logic [1:0] stageQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            stageQ <= 2'b11;
        end else begin
            stageQ <= {stageQ[0], asyncIn};
        end
    end

    assign syncOut = stageQ[1];

endmodule

// File: rtl/blood_sensor_rx.sv
// Serial receiver for the blood sensor: start/8 data MSB first/even parity/stop,
// delivering a registered bloodSensor word with one-cycle status strobes.
module blood_sensor_rx
    import blood_sensor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = SENSOR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensorRx,
    output logic [DATA_W-1:0] bloodSensor,
    output logic              sensorValid,
    output logic              parityError,
    output logic              frameError,
    output logic              busy
);

    localparam int unsigned TimerW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitCntW = $clog2(DATA_W);
    localparam logic [TimerW-1:0]  HalfBit = TimerW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TimerW-1:0]  FullBit = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

    logic rxS;

    sync_2ff u_sync (
        .clk     (clk),
        .rst     (rst),
        .asyncIn (sensorRx),
        .syncOut (rxS)
    );

    rx_state_t          stateQ, stateD;
    logic [TimerW-1:0]  timerQ, timerD;
    logic [BitCntW-1:0] bitCntQ, bitCntD;
    logic [DATA_W-1:0]  shiftQ, shiftD;
    logic               parityQ, parityD;
    logic [DATA_W-1:0]  bloodQ, bloodD;
    logic               validQ, validD;
    logic               parErrQ, parErrD;
    logic               frmErrQ, frmErrD;
    logic               busyQ, busyD;
    logic [1:0]         settleQ;
    logic               armedQ;
    logic               timerDone;

    // rxS reflects the real line only once the synchronizer has flushed its reset
    // value; a start needs a genuine high first, so a frame cut by reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            settleQ <= 2'b11;
            armedQ  <= 1'b0;
        end else begin
            settleQ <= {settleQ[0], 1'b0};
            armedQ  <= armedQ | (~settleQ[1] & rxS);
        end
    end

    assign timerDone = (timerQ == '0);

    always_comb begin
        stateD  = stateQ;
        timerD  = timerQ;
        bitCntD = bitCntQ;
        shiftD  = shiftQ;
        parityD = parityQ;
        bloodD  = bloodQ;
        validD  = 1'b0;
        parErrD = 1'b0;
        frmErrD = 1'b0;
        case (stateQ)
            StIdle: begin
                if (armedQ && !rxS) begin
                    stateD = StStart;
                    timerD = HalfBit;
                end
            end
            StStart: begin
                if (!timerDone) begin
                    timerD = timerQ - 1'b1;
                end else if (!rxS) begin
                    stateD  = StData;
                    timerD  = FullBit;
                    bitCntD = '0;
                end else begin
                    stateD = StIdle;
                end
            end
            StData: begin
                if (!timerDone) begin
                    timerD = timerQ - 1'b1;
                end else begin
                    shiftD  = {shiftQ[DATA_W-2:0], rxS};
                    bitCntD = bitCntQ + 1'b1;
                    timerD  = FullBit;
                    if (bitCntQ == LastBit) begin
                        stateD = StParity;
                    end
                end
            end
            StParity: begin
                if (!timerDone) begin
                    timerD = timerQ - 1'b1;
                end else begin
                    parityD = rxS;
                    timerD  = FullBit;
                    stateD  = StStop;
                end
            end
            StStop: begin
                if (!timerDone) begin
                    timerD = timerQ - 1'b1;
                end else if (!rxS) begin
                    frmErrD = 1'b1;
                    stateD  = StBreak;
                end else begin
                    stateD = StIdle;
                    if (even_parity(shiftQ, parityQ)) begin
                        bloodD = shiftQ;
                        validD = 1'b1;
                    end else begin
                        parErrD = 1'b1;
                    end
                end
            end
            StBreak: begin
                if (rxS) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
        busyD = (stateD != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= StIdle;
            timerQ  <= '0;
            bitCntQ <= '0;
            shiftQ  <= '0;
            parityQ <= 1'b0;
            bloodQ  <= '0;
            validQ  <= 1'b0;
            parErrQ <= 1'b0;
            frmErrQ <= 1'b0;
            busyQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            timerQ  <= timerD;
            bitCntQ <= bitCntD;
            shiftQ  <= shiftD;
            parityQ <= parityD;
            bloodQ  <= bloodD;
            validQ  <= validD;
            parErrQ <= parErrD;
            frmErrQ <= frmErrD;
            busyQ   <= busyD;
        end
    end

    assign bloodSensor = bloodQ;
    assign sensorValid = validQ;
    assign parityError = parErrQ;
    assign frameError  = frmErrQ;
    assign busy        = busyQ;

endmodule

// File: tb/tb_blood_sensor_rx.sv
// Directed bench for blood_sensor_rx: frame timing, back-to-back, parity/frame errors,
// glitch rejection and mid-frame reset.
module tb_blood_sensor_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensorRx;
    logic [7:0] bloodSensor;
    logic       sensorValid;
    logic       parityError;
    logic       frameError;
    logic       busy;

    int nCompared = 0;
    int nMismatch = 0;
    int cyc = 0;
    int fallCyc;
    int parErrCnt = 0;
    int frmErrCnt = 0;
    int overlapCnt = 0;
    int validCycQ[$];
    logic [7:0] validDataQ[$];

    blood_sensor_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensorRx    (sensorRx),
        .bloodSensor (bloodSensor),
        .sensorValid (sensorValid),
        .parityError (parityError),
        .frameError  (frameError),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sensorValid === 1'b1) begin
            validCycQ.push_back(cyc);
            validDataQ.push_back(bloodSensor);
        end
        if (parityError === 1'b1) parErrCnt++;
        if (frameError === 1'b1) frmErrCnt++;
        if (int'(sensorValid === 1'b1) + int'(parityError === 1'b1)
            + int'(frameError === 1'b1) > 1) overlapCnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        validCycQ.delete();
        validDataQ.delete();
        parErrCnt = 0;
        frmErrCnt = 0;
    endtask

    task automatic drive_bit(input logic b);
        sensorRx = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stopB);
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(data[i]);
        drive_bit(par);
        drive_bit(stopB);
    endtask

    task automatic test_reset();
        sensorRx = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nCompared++;
        if (bloodSensor !== 8'h00) begin
            nMismatch++;
            $display("FAIL reset_blood got=%h exp=00", bloodSensor);
        end
        nCompared++;
        if ({sensorValid, parityError, frameError, busy} !== 4'b0000) begin
            nMismatch++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {sensorValid, parityError, frameError, busy});
        end
        repeat (4) tick();
    endtask

    task automatic test_single_frame();
        clear_log();
        fallCyc = cyc;
        send_frame(8'hEE, 1'b0, 1'b1);
        drive_bit(1'b1);
        nCompared++;
        if (validCycQ.size() !== 1) begin
            nMismatch++;
            $display("FAIL single_valid_count got=%0d exp=1", validCycQ.size());
        end else begin
            nCompared++;
            if (validCycQ[0] - fallCyc !== 171) begin
                nMismatch++;
                $display("FAIL single_latency got=%0d exp=171", validCycQ[0] - fallCyc);
            end
            nCompared++;
            if (validDataQ[0] !== 8'hEE) begin
                nMismatch++;
                $display("FAIL single_data got=%h exp=ee", validDataQ[0]);
            end
        end
        nCompared++;
        if (parErrCnt + frmErrCnt !== 0) begin
            nMismatch++;
            $display("FAIL single_errors got=%0d exp=0", parErrCnt + frmErrCnt);
        end
        nCompared++;
        if (busy !== 1'b0) begin
            nMismatch++;
            $display("FAIL single_busy_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [4];
        vec[0] = 8'h7C;
        vec[1] = 8'h9D;
        vec[2] = 8'hFF;
        vec[3] = 8'h00;
        clear_log();
        fallCyc = cyc;
        for (int i = 0; i < 4; i++) send_frame(vec[i], ^vec[i], 1'b1);
        drive_bit(1'b1);
        nCompared++;
        if (validCycQ.size() !== 4) begin
            nMismatch++;
            $display("FAIL b2b_count got=%0d exp=4", validCycQ.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < validCycQ.size()) begin
                nCompared++;
                if (validCycQ[i] - fallCyc !== 171 + 176 * i) begin
                    nMismatch++;
                    $display("FAIL b2b_time[%0d] got=%0d exp=%0d", i,
                             validCycQ[i] - fallCyc, 171 + 176 * i);
                end
                nCompared++;
                if (validDataQ[i] !== vec[i]) begin
                    nMismatch++;
                    $display("FAIL b2b_data[%0d] got=%h exp=%h", i, validDataQ[i], vec[i]);
                end
            end
        end
        nCompared++;
        if (parErrCnt + frmErrCnt !== 0) begin
            nMismatch++;
            $display("FAIL b2b_errors got=%0d exp=0", parErrCnt + frmErrCnt);
        end
    endtask

    task automatic test_parity_error();
        clear_log();
        send_frame(8'h55, 1'b1, 1'b1);
        drive_bit(1'b1);
        nCompared++;
        if (parErrCnt !== 1) begin
            nMismatch++;
            $display("FAIL parity_err_count got=%0d exp=1", parErrCnt);
        end
        nCompared++;
        if (validCycQ.size() !== 0 || frmErrCnt !== 0) begin
            nMismatch++;
            $display("FAIL parity_other_pulses got valid=%0d frm=%0d exp=0/0",
                     validCycQ.size(), frmErrCnt);
        end
        nCompared++;
        if (bloodSensor !== 8'h00) begin
            nMismatch++;
            $display("FAIL parity_hold got=%h exp=00", bloodSensor);
        end
    endtask

    task automatic test_break();
        clear_log();
        send_frame(8'hAA, 1'b0, 1'b0);
        repeat (40) drive_bit(1'b0);
        nCompared++;
        if (frmErrCnt !== 1) begin
            nMismatch++;
            $display("FAIL break_frm_count got=%0d exp=1", frmErrCnt);
        end
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatch++;
            $display("FAIL break_busy got=%b exp=1", busy);
        end
        nCompared++;
        if (validCycQ.size() !== 0 || parErrCnt !== 0 || bloodSensor !== 8'h00) begin
            nMismatch++;
            $display("FAIL break_side got valid=%0d par=%0d blood=%h exp=0/0/00",
                     validCycQ.size(), parErrCnt, bloodSensor);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        nCompared++;
        if (busy !== 1'b0) begin
            nMismatch++;
            $display("FAIL break_release got=%b exp=0", busy);
        end
        send_frame(8'h81, 1'b0, 1'b1);
        drive_bit(1'b1);
        nCompared++;
        if (bloodSensor !== 8'h81 || validCycQ.size() !== 1 || frmErrCnt !== 1) begin
            nMismatch++;
            $display("FAIL break_next got blood=%h valid=%0d frm=%0d exp=81/1/1",
                     bloodSensor, validCycQ.size(), frmErrCnt);
        end
    endtask

    task automatic test_glitch();
        clear_log();
        sensorRx = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 5) sensorRx = 1'b1;
            if (c == 10) begin
                nCompared++;
                if (busy !== 1'b1) begin
                    nMismatch++;
                    $display("FAIL glitch_busy_start got=%b exp=1", busy);
                end
            end
            if (c == 11) begin
                nCompared++;
                if (busy !== 1'b0) begin
                    nMismatch++;
                    $display("FAIL glitch_busy_drop got=%b exp=0", busy);
                end
            end
        end
        drive_bit(1'b1);
        nCompared++;
        if (validCycQ.size() + parErrCnt + frmErrCnt !== 0) begin
            nMismatch++;
            $display("FAIL glitch_pulses got=%0d exp=0",
                     validCycQ.size() + parErrCnt + frmErrCnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(1'b1);
        sensorRx = 1'b0;
        repeat (2) tick();
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatch++;
            $display("FAIL midrst_busy_before got=%b exp=1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nCompared++;
        if ({bloodSensor, sensorValid, parityError, frameError, busy} !== 12'h000) begin
            nMismatch++;
            $display("FAIL midrst_outputs got=%h exp=000",
                     {bloodSensor, sensorValid, parityError, frameError, busy});
        end
        repeat (CPB - 3) tick();
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        nCompared++;
        if (busy !== 1'b0 || validCycQ.size() + parErrCnt + frmErrCnt !== 0) begin
            nMismatch++;
            $display("FAIL midrst_ignored got busy=%b pulses=%0d exp=0/0", busy,
                     validCycQ.size() + parErrCnt + frmErrCnt);
        end
        send_frame(8'h80, 1'b1, 1'b1);
        drive_bit(1'b1);
        nCompared++;
        if (bloodSensor !== 8'h80 || validCycQ.size() !== 1) begin
            nMismatch++;
            $display("FAIL midrst_next got blood=%h valid=%0d exp=80/1",
                     bloodSensor, validCycQ.size());
        end
        nCompared++;
        if (overlapCnt !== 0) begin
            nMismatch++;
            $display("FAIL pulse_overlap got=%0d exp=0", overlapCnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        sensorRx = 1'b1;
        tick();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_error();
        test_break();
        test_glitch();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
